uart_tx_responder: RTL and testbench

Memory-mapped UART transmitter that responds to the CPU's data-memory port (port A) protocol: write enable, read enable, byte address, write data, and read data returned one cycle later. Bytes written to the data register are queued in a small FIFO and serialized as 8N1 frames on `uart_tx`. A status register reports busy, full, empty, overflow and fill count. It sits behind the SoC address decoder, alongside RAM, with `sel` driven by the decoder.

---
 rtl/uart_tx_responder_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_responder.sv | 159 +++++++++++++++
 tb/tb_uart_tx_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_responder_pkg.sv
// Shared register map, STATUS bit positions, TX FSM encodings and bus width codes
// for the UART transmitter and its future receiver companion.
package uart_tx_responder_pkg;

   localparam logic [3:0] UART_TXDATA = 4'h0;
   localparam logic [3:0] UART_STATUS = 4'h4;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Shared by weA and reA[1:0]
   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port: TXDATA pushes into a
// FIFO drained by the TX FSM, STATUS reports busy/full/empty/overflow/count.
module uart_tx_responder
   import uart_tx_responder_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int FIFO_AW   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [1:0]  weA,
   input  logic [2:0]  reA,
   input  logic [3:0]  addrA,
   input  logic [31:0] dinA,
   output logic [31:0] doutA,
   output logic        uart_tx
);

   localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
   localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [TW-1:0] TICK_RELOAD = TW'(BIT_TICKS - 1);

   logic             push, pop, rd_en, rd_status, busy;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [FIFO_AW:0] fifo_count;
   logic [31:0]      status_w, doutA_q, doutA_d;
   logic             ovf_q, ovf_d;
   tx_state_e        state_q;
   logic [TW-1:0]    tick_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             unused_din;

   assign unused_din = ^dinA[31:8];

   function automatic logic [31:0] size_extend(input logic [31:0] d, input logic [2:0] re);
      case (re[1:0])
         SZ_BYTE: return re[2] ? {{24{d[7]}}, d[7:0]}   : {24'h0, d[7:0]};
         SZ_HALF: return re[2] ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign push      = sel && (weA != SZ_NONE) && (addrA == UART_TXDATA);
   assign rd_en     = sel && (reA[1:0] != SZ_NONE);
   assign rd_status = rd_en && (addrA == UART_STATUS);
   assign busy      = (state_q != TX_IDLE);
   assign pop       = !fifo_empty &&
                      ((state_q == TX_IDLE) || ((state_q == TX_STOP) && (tick_q == '0)));

   sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (dinA[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      status_w                       = '0;
      status_w[ST_BUSY]              = busy;
      status_w[ST_FULL]              = fifo_full;
      status_w[ST_EMPTY]             = fifo_empty;
      status_w[ST_OVF]               = ovf_q;
      status_w[ST_COUNT_LSB +: 8]    = 8'(fifo_count);

      doutA_d = '0;
      if (rd_status)  doutA_d = size_extend(status_w, reA);

      // A dropped push in the same cycle as a STATUS read leaves overflow set
      ovf_d = ovf_q;
      if (rd_status) ovf_d = 1'b0;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         doutA_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         doutA_q <= doutA_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= TX_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (pop) begin
                  shift_q <= fifo_dout;
                  tick_q  <= TICK_RELOAD;
                  state_q <= TX_START;
                  tx_q    <= 1'b0;
               end
            end
            TX_START: begin
               if (tick_q == '0) begin
                  tick_q  <= TICK_RELOAD;
                  bit_q   <= '0;
                  state_q <= TX_DATA;
                  tx_q    <= shift_q[0];
               end else begin
                  tick_q <= tick_q - TW'(1);
               end
            end
            TX_DATA: begin
               if (tick_q == '0) begin
                  tick_q  <= TICK_RELOAD;
                  shift_q <= shift_q >> 1;
                  if (bit_q == 3'd7) begin
                     state_q <= TX_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= shift_q[1];
                  end
               end else begin
                  tick_q <= tick_q - TW'(1);
               end
            end
            TX_STOP: begin
               // Chain straight into the next start bit when more data is queued
               if (tick_q == '0) begin
                  if (pop) begin
                     shift_q <= fifo_dout;
                     tick_q  <= TICK_RELOAD;
                     state_q <= TX_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  tick_q <= tick_q - TW'(1);
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign doutA   = doutA_q;
   assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder with BIT_TICKS = 10 and a 4-entry FIFO;
// a line monitor decodes frames with their start cycle for byte and gap checks.
module tb_uart_tx_responder;

   localparam int BT = 10;
   localparam logic [3:0] A_TX = 4'h0;
   localparam logic [3:0] A_ST = 4'h4;
   localparam logic [2:0] LW  = 3'b011;
   localparam logic [2:0] LB  = 3'b101;
   localparam logic [2:0] LBU = 3'b001;
   localparam logic [2:0] LH  = 3'b110;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [1:0]  weA;
   logic [2:0]  reA;
   logic [3:0]  addrA;
   logic [31:0] dinA;
   logic [31:0] doutA;
   logic        uart_tx;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] rx_byte[$];
   int         rx_start[$];
   logic       rx_stop[$];

   uart_tx_responder #(.CLK_FREQ(20), .BAUD_RATE(2), .FIFO_AW(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .weA     (weA),
      .reA     (reA),
      .addrA   (addrA),
      .dinA    (dinA),
      .doutA   (doutA),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      sel = 1'b0; weA = 2'b00; reA = 3'b000; addrA = 4'h0; dinA = 32'h0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [1:0] we);
      sel = 1'b1; weA = we; reA = 3'b000; addrA = a; dinA = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [2:0] re, output logic [31:0] d);
      sel = 1'b1; weA = 2'b00; reA = re; addrA = a; dinA = 32'h0;
      @(negedge clk);
      d = doutA;
      bus_idle();
   endtask

   task automatic clear_rx();
      rx_byte.delete(); rx_start.delete(); rx_stop.delete();
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] st;
      st = 32'h1;
      for (int n = 0; n < 1000; n++) begin
         bus_read(A_ST, LW, st);
         if (!st[0]) break;
      end
      check({tag, " idle"}, {31'h0, st[0]}, 32'h0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_frames(input string tag, input logic [7:0] first, input int n);
      check({tag, " frames"}, rx_byte.size(), n);
      for (int i = 0; i < rx_byte.size() && i < n; i++) begin
         check($sformatf("%s byte%0d", tag, i), {24'h0, rx_byte[i]}, {24'h0, first + 8'(i)});
         check($sformatf("%s stop%0d", tag, i), {31'h0, rx_stop[i]}, 32'h1);
         if (i > 0)
            check($sformatf("%s gap%0d", tag, i), rx_start[i] - rx_start[i-1], 10 * BT);
      end
   endtask

   // Line monitor: samples mid-bit, drops frames cut short by reset
   initial begin
      logic [7:0] b;
      logic       stop, abort;
      int         t0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && uart_tx === 1'b0) begin
            t0 = cyc; abort = 1'b0; b = 8'h0; stop = 1'b0;
            for (int i = 1; i < 10 * BT; i++) begin
               @(negedge clk);
               if (rst !== 1'b0) abort = 1'b1;
               if (i % BT == BT / 2 && i > BT && i < 9 * BT) b[(i / BT) - 1] = uart_tx;
               if (i == 9 * BT + BT / 2) stop = uart_tx;
            end
            if (!abort) begin
               rx_byte.push_back(b); rx_start.push_back(t0); rx_stop.push_back(stop);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [9:0]  fr;
      bus_idle();
      rst = 1'b1;
      #1;
      check("reset tx", {31'h0, uart_tx}, 32'h1);
      check("reset dout", doutA, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_read(A_ST, LW, d);
      check("reset status", d, 32'h0000_0004);

      // Ignored accesses
      sel = 1'b0; weA = 2'b11; addrA = A_TX; dinA = 32'h77;
      @(negedge clk);
      sel = 1'b0; weA = 2'b00; reA = LW; addrA = A_ST;
      @(negedge clk);
      check("unsel read", doutA, 32'h0);
      bus_idle();
      bus_write(4'h8, 32'h88, 2'b11);
      bus_write(A_ST, 32'h99, 2'b11);
      bus_read(A_ST, LW, d);
      check("ignored status", d, 32'h0000_0004);
      repeat (20) @(negedge clk);
      check("ignored frames", rx_byte.size(), 0);
      check("ignored tx", {31'h0, uart_tx}, 32'h1);

      // Single byte, cycle-exact line trace
      clear_rx();
      bus_write(A_TX, 32'h1234_56A5, 2'b01);
      check("sb pre", {31'h0, uart_tx}, 32'h1);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10 * BT; i++) begin
         @(negedge clk);
         check($sformatf("sb tx[%0d]", i), {31'h0, uart_tx}, {31'h0, fr[i / BT]});
      end
      bus_read(A_ST, LW, d);
      check("sb busy last", d, 32'h0000_0005);
      bus_read(A_ST, LW, d);
      check("sb idle", d, 32'h0000_0004);
      repeat (4) @(negedge clk);
      check_frames("sb", 8'hA5, 1);

      // Fill, overflow and read widths
      clear_rx();
      for (int i = 1; i <= 6; i++) bus_write(A_TX, 32'(i), 2'b11);
      bus_read(A_ST, LW, d);  check("ovf status", d, 32'h0000_040B);
      bus_read(A_ST, LW, d);  check("ovf cleared", d, 32'h0000_0403);
      bus_read(A_ST, LB, d);  check("lb status", d, 32'h0000_0003);
      bus_read(A_ST, LBU, d); check("lbu status", d, 32'h0000_0003);
      bus_read(A_ST, LH, d);  check("lh status", d, 32'h0000_0403);
      bus_read(A_TX, LB, d);  check("lb txdata", d, 32'h0);
      @(negedge clk);
      check("no read", doutA, 32'h0);
      wait_idle("fill");
      check_frames("fill", 8'h01, 5);

      // Push on the STOP last tick with the FIFO full
      clear_rx();
      for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h11 + 32'(i), 2'b11);
      repeat (96) @(negedge clk);
      bus_write(A_TX, 32'h16, 2'b11);
      bus_read(A_ST, LW, d);
      check("pushpop status", d, 32'h0000_0403);
      wait_idle("pushpop");
      check_frames("pushpop", 8'h11, 6);

      // Reset during DATA bit 3 (bit 3 of 0x37 is 0)
      clear_rx();
      bus_write(A_TX, 32'h37, 2'b11);
      repeat (43) @(negedge clk);
      bus_read(A_ST, LW, d);
      check("mid status", d, 32'h0000_0005);
      check("mid low", {31'h0, uart_tx}, 32'h0);
      #1 rst = 1'b1;
      #1;
      check("rst tx", {31'h0, uart_tx}, 32'h1);
      check("rst dout", doutA, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_read(A_ST, LW, d);
      check("post rst status", d, 32'h0000_0004);
      repeat (150) @(negedge clk);
      check("post rst frames", rx_byte.size(), 0);
      check("post rst tx", {31'h0, uart_tx}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
